// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: holds the PLL in reset, qualifies its lock and
// releases the system and DSP resets in two stages.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 100000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_DELAY    = 256,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       dsp_rst_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [7:0] relock_count_o,
  output logic [7:0] timeout_count_o
);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE_SYS,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] PLL_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST =
    CNT_W'(STAGE_DELAY - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic lock_m;
  logic lock_s;

  logic       lost;
  logic       tmo;
  logic       pll_rst_d;
  logic       sys_rst_n_d;
  logic       dsp_rst_n_d;
  logic       ready_d;
  logic [7:0] relock_d;
  logic [7:0] timeout_d;

  // locked comes straight from the PLL analog block
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= locked;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    lost    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      S_PLL_RESET: begin
        if (cnt_q == PLL_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          tmo     = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RELEASE_SYS;
          cnt_d   = '0;
        end
      end
      S_RELEASE_SYS: begin
        if (!lock_s) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (cnt_q == STG_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          lost    = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs are decoded from the next state so they land on the transition edge
  always_comb begin
    pll_rst_d   = (state_d == S_PLL_RESET);
    sys_rst_n_d = (state_d == S_RELEASE_SYS) ||
                  (state_d == S_RUN);
    dsp_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    relock_d    = relock_count_o;
    timeout_d   = timeout_count_o;
    if (lost && relock_count_o != 8'hFF)
      relock_d = relock_count_o + 8'd1;
    if (tmo && timeout_count_o != 8'hFF)
      timeout_d = timeout_count_o + 8'd1;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q         <= S_PLL_RESET;
      cnt_q           <= '0;
      pll_rst_o       <= 1'b1;
      sys_rst_n_o     <= 1'b0;
      dsp_rst_n_o     <= 1'b0;
      ready_o         <= 1'b0;
      lock_lost_o     <= 1'b0;
      relock_count_o  <= 8'd0;
      timeout_count_o <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pll_rst_o       <= pll_rst_d;
      sys_rst_n_o     <= sys_rst_n_d;
      dsp_rst_n_o     <= dsp_rst_n_d;
      ready_o         <= ready_d;
      lock_lost_o     <= lost;
      relock_count_o  <= relock_d;
      timeout_count_o <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Event scoreboard for pll_reset_sequencer: every output change is
// matched against a queued (cycle, value) expectation.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LTO = 64;
  localparam int STC = 16;
  localparam int SDL = 8;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       dsp_rst_n_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [7:0] relock_count_o;
  logic [7:0] timeout_count_o;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .STAGE_DELAY   (SDL),
    .CNT_W         (20)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .locked         (locked),
    .pll_rst_o      (pll_rst_o),
    .sys_rst_n_o    (sys_rst_n_o),
    .dsp_rst_n_o    (dsp_rst_n_o),
    .ready_o        (ready_o),
    .lock_lost_o    (lock_lost_o),
    .relock_count_o (relock_count_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [20:0] v;
  } ev_t;

  ev_t exp_q[$];

  logic       e_pll = 1'b1;
  logic       e_sys = 1'b0;
  logic       e_dsp = 1'b0;
  logic       e_rdy = 1'b0;
  logic       e_ll  = 1'b0;
  logic [7:0] e_rc  = 8'd0;
  logic [7:0] e_tc  = 8'd0;
  bit         done  = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic push(input int c);
    ev_t e;
    e.c = c;
    e.v = {e_pll, e_sys, e_dsp, e_rdy, e_ll, e_rc, e_tc};
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  // stimulus: each action queues the output changes it must cause
  initial begin
    int r, l, d, m, g, t, w0;
    push(1);
    wait_cyc(3);
    r = cyc;
    rst_n = 1'b1;
    e_pll = 1'b0;
    push(r + PRC);

    // power-up
    wait_cyc(r + PRC + 10);
    l = cyc;
    locked = 1'b1;
    e_sys = 1'b1;
    push(l + STC + 3);
    e_dsp = 1'b1;
    e_rdy = 1'b1;
    push(l + STC + 3 + SDL);

    // lock loss in RUN, then full re-lock
    wait_cyc(l + STC + 3 + SDL + 3);
    d = cyc;
    locked = 1'b0;
    e_pll = 1'b1; e_sys = 1'b0; e_dsp = 1'b0;
    e_rdy = 1'b0; e_ll = 1'b1; e_rc = 8'd1;
    push(d + 3);
    e_ll = 1'b0;
    push(d + 4);
    e_pll = 1'b0;
    push(d + 3 + PRC);
    wait_cyc(d + 3 + PRC + 3);
    l = cyc;
    locked = 1'b1;
    e_sys = 1'b1;
    push(l + STC + 3);
    e_dsp = 1'b1;
    e_rdy = 1'b1;
    push(l + STC + 3 + SDL);

    // one-cycle reset mid-RUN with locked held high
    wait_cyc(l + STC + 3 + SDL + 3);
    m = cyc;
    rst_n = 1'b0;
    e_pll = 1'b1; e_sys = 1'b0; e_dsp = 1'b0;
    e_rdy = 1'b0; e_rc = 8'd0;
    push(m + 1);
    wait_cyc(m + 1);
    rst_n = 1'b1;
    e_pll = 1'b0;
    push(m + 1 + PRC);
    e_sys = 1'b1;
    push(m + 1 + PRC + 1 + STC);

    // lock loss three cycles into RELEASE_SYS
    wait_cyc(m + 1 + PRC + 1 + STC + 3);
    d = cyc;
    locked = 1'b0;
    e_pll = 1'b1; e_sys = 1'b0; e_ll = 1'b1; e_rc = 8'd1;
    push(d + 3);
    e_ll = 1'b0;
    push(d + 4);
    e_pll = 1'b0;
    push(d + 3 + PRC);

    // two-cycle glitch at qualification cycle 10
    wait_cyc(d + 3 + PRC + 3);
    g = cyc;
    locked = 1'b1;
    wait_cyc(g + 3 + 10);
    locked = 1'b0;
    wait_cyc(g + 15);
    locked = 1'b1;
    e_sys = 1'b1;
    push(g + 15 + STC + 3);
    e_dsp = 1'b1;
    e_rdy = 1'b1;
    push(g + 15 + STC + 3 + SDL);

    // lose lock for good: 300 timeouts, count saturates
    wait_cyc(g + 15 + STC + 3 + SDL + 3);
    t = cyc;
    locked = 1'b0;
    e_pll = 1'b1; e_sys = 1'b0; e_dsp = 1'b0;
    e_rdy = 1'b0; e_ll = 1'b1; e_rc = 8'd2;
    push(t + 3);
    e_ll = 1'b0;
    push(t + 4);
    e_pll = 1'b0;
    push(t + 3 + PRC);
    w0 = t + 3 + PRC;
    for (int k = 1; k <= 300; k++) begin
      e_pll = 1'b1;
      if (e_tc != 8'hFF) e_tc = e_tc + 8'd1;
      push(w0 + k * LTO + (k - 1) * PRC);
      e_pll = 1'b0;
      push(w0 + k * (LTO + PRC));
    end
    wait_cyc(w0 + 300 * (LTO + PRC) + 10);
    done = 1'b1;
  end

  // monitor: any output change must match the head of the queue
  initial begin
    logic [21:0] prev;
    logic [20:0] cur;
    ev_t         e;
    prev = '1;
    forever begin
      @(negedge refclk);
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_events actual=%0d required=0",
                   exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      cur = {pll_rst_o, sys_rst_n_o, dsp_rst_n_o, ready_o,
             lock_lost_o, relock_count_o, timeout_count_o};
      if ({1'b0, cur} !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d actual=%h required=none",
                   cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.c != cyc || e.v !== cur) begin
            errors++;
            $display("FAIL out_event actual=%h@%0d required=%h@%0d",
                     cur, cyc, e.v, e.c);
          end
        end
        prev = {1'b0, cur};
      end
    end
  end

endmodule
